axi4lite_ctrl_slave: RTL and testbench

AXI4LITE_CTRL_SLAVE -- requirements
Module: axi4lite_ctrl_slave

---
 rtl/axi4lite_ctrl_slave_pkg.sv | 26 ++
 rtl/axi4lite_ctrl_slave.sv | 199 +++++++++++++++++++
 tb/tb_axi4lite_ctrl_slave.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_ctrl_slave_pkg.sv
// Shared constants and FSM state encoding for the AXI4-Lite control slave.
package axi4lite_ctrl_slave_pkg;

  localparam int CTRL_ADDR_W = 11;
  localparam int CTRL_DATA_W = 32;
  localparam int CTRL_STRB_W = CTRL_DATA_W / 8;
  localparam int CTRL_WORD_W = CTRL_ADDR_W - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Controller state enumeration, kept as plain constants for older tools.
  typedef logic [2:0] ctrl_state_t;
  localparam ctrl_state_t ST_IDLE     = 3'd0;
  localparam ctrl_state_t ST_WR_ISSUE = 3'd1;
  localparam ctrl_state_t ST_WR_RESP  = 3'd2;
  localparam ctrl_state_t ST_RD_ISSUE = 3'd3;
  localparam ctrl_state_t ST_RD_WAIT  = 3'd4;
  localparam ctrl_state_t ST_RD_RESP  = 3'd5;

  // Rebuild a word-aligned byte address from a stored word index.
  function automatic logic [CTRL_ADDR_W-1:0] word_to_addr(input logic [CTRL_WORD_W-1:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/axi4lite_ctrl_slave.sv
// AXI4-Lite slave that turns AXI register accesses into single transactions
// on a simple downstream control bus, one outstanding access at a time.
module axi4lite_ctrl_slave
  import axi4lite_ctrl_slave_pkg::*;
#(
  parameter int RD_TIMEOUT = 255
) (
  input  logic                   CLOCK,
  input  logic                   RESETN,
  input  logic                   CTRL_AWVALID,
  output logic                   CTRL_AWREADY,
  input  logic [CTRL_ADDR_W-1:0] CTRL_AWADDR,
  input  logic                   CTRL_WVALID,
  output logic                   CTRL_WREADY,
  input  logic [CTRL_DATA_W-1:0] CTRL_WDATA,
  input  logic [CTRL_STRB_W-1:0] CTRL_WSTRB,
  output logic                   CTRL_BVALID,
  input  logic                   CTRL_BREADY,
  output logic [1:0]             CTRL_BRESP,
  input  logic                   CTRL_ARVALID,
  output logic                   CTRL_ARREADY,
  input  logic [CTRL_ADDR_W-1:0] CTRL_ARADDR,
  output logic                   CTRL_RVALID,
  input  logic                   CTRL_RREADY,
  output logic [CTRL_DATA_W-1:0] CTRL_RDATA,
  output logic [1:0]             CTRL_RRESP,
  output logic                   ctrlWrEn,
  output logic                   ctrlRdEn,
  output logic [CTRL_ADDR_W-1:0] ctrlAddr,
  output logic [CTRL_DATA_W-1:0] ctrlWrData,
  output logic [CTRL_STRB_W-1:0] ctrlWrStrbs,
  input  logic                   ctrlWrReady,
  input  logic                   ctrlRdValid,
  input  logic [CTRL_DATA_W-1:0] ctrlRdData
);

  localparam int CNT_W = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RD_TIMEOUT - 1);

  logic                   aw_full;
  logic                   w_full;
  logic                   ar_full;
  logic                   ready_en;
  logic [CTRL_WORD_W-1:0] aw_word;
  logic [CTRL_WORD_W-1:0] ar_word;
  logic [CTRL_DATA_W-1:0] w_data;
  logic [CTRL_STRB_W-1:0] w_strb;
  ctrl_state_t            state;
  logic                   last_served_rd;
  logic [CNT_W-1:0]       rd_cnt;
  logic [CTRL_DATA_W-1:0] rdata;
  logic [1:0]             rresp;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   ar_hs;
  logic                   wr_pend;
  logic                   rd_pend;
  logic                   wr_done;
  logic                   rd_issue;
  logic                   unused_addr_lsbs;

  // The low two address bits never matter: every access is a full word.
  assign unused_addr_lsbs = ^{CTRL_AWADDR[1:0], CTRL_ARADDR[1:0]};

  // READY simply mirrors an empty holding register once reset has been released.
  assign CTRL_AWREADY = ready_en & ~aw_full;
  assign CTRL_WREADY  = ready_en & ~w_full;
  assign CTRL_ARREADY = ready_en & ~ar_full;

  assign aw_hs = CTRL_AWVALID & CTRL_AWREADY;
  assign w_hs  = CTRL_WVALID & CTRL_WREADY;
  assign ar_hs = CTRL_ARVALID & CTRL_ARREADY;

  // A request counts as pending in the very cycle it is handshaken, which
  // lets IDLE issue on the following cycle without an extra bubble.
  assign wr_pend  = (aw_full | aw_hs) & (w_full | w_hs);
  assign rd_pend  = ar_full | ar_hs;
  assign wr_done  = (state == ST_WR_ISSUE) & ctrlWrReady;
  assign rd_issue = (state == ST_RD_ISSUE);

  // One-deep holding registers for AW, W and AR; freed once the FSM consumes them.
  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      ar_full  <= 1'b0;
      ready_en <= 1'b0;
      aw_word  <= '0;
      ar_word  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_word <= CTRL_AWADDR[CTRL_ADDR_W-1:2];
      end else if (wr_done) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= CTRL_WDATA;
        w_strb <= CTRL_WSTRB;
      end else if (wr_done) begin
        w_full <= 1'b0;
      end
      if (ar_hs) begin
        ar_full <= 1'b1;
        ar_word <= CTRL_ARADDR[CTRL_ADDR_W-1:2];
      end else if (rd_issue) begin
        ar_full <= 1'b0;
      end
    end
  end

  // Transaction FSM; last_served_rd remembers the winner of the most recent
  // contested arbitration so back-to-back conflicts alternate between types.
  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      state          <= ST_IDLE;
      last_served_rd <= 1'b1;
      rd_cnt         <= '0;
      rdata          <= '0;
      rresp          <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_pend && rd_pend) begin
            if (last_served_rd) begin
              state          <= ST_WR_ISSUE;
              last_served_rd <= 1'b0;
            end else begin
              state          <= ST_RD_ISSUE;
              last_served_rd <= 1'b1;
            end
          end else if (wr_pend) begin
            state <= ST_WR_ISSUE;
          end else if (rd_pend) begin
            state <= ST_RD_ISSUE;
          end
        end
        ST_WR_ISSUE: begin
          if (ctrlWrReady) state <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (CTRL_BREADY) state <= ST_IDLE;
        end
        ST_RD_ISSUE: begin
          rd_cnt <= '0;
          if (ctrlRdValid) begin
            rdata <= ctrlRdData;
            rresp <= RESP_OKAY;
            state <= ST_RD_RESP;
          end else begin
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          rd_cnt <= rd_cnt + CNT_W'(1);
          if (ctrlRdValid) begin
            rdata <= ctrlRdData;
            rresp <= RESP_OKAY;
            state <= ST_RD_RESP;
          end else if (rd_cnt >= TIMEOUT_LAST) begin
            rdata <= '0;
            rresp <= RESP_SLVERR;
            state <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (CTRL_RREADY) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register-bus and response outputs decode straight from the state.
  always_comb begin
    ctrlWrEn    = (state == ST_WR_ISSUE);
    ctrlRdEn    = (state == ST_RD_ISSUE);
    ctrlAddr    = '0;
    ctrlWrData  = '0;
    ctrlWrStrbs = '0;
    if (ctrlWrEn) begin
      ctrlAddr    = word_to_addr(aw_word);
      ctrlWrData  = w_data;
      ctrlWrStrbs = w_strb;
    end else if (ctrlRdEn) begin
      ctrlAddr = word_to_addr(ar_word);
    end
    CTRL_BVALID = (state == ST_WR_RESP);
    CTRL_BRESP  = RESP_OKAY;
    CTRL_RVALID = (state == ST_RD_RESP);
    CTRL_RDATA  = rdata;
    CTRL_RRESP  = rresp;
  end

endmodule

// File: tb/tb_axi4lite_ctrl_slave.sv
// Self-checking bench for axi4lite_ctrl_slave: directed scenarios plus a
// randomized phase checked against a word-level memory model.
module tb_axi4lite_ctrl_slave;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        CTRL_AWVALID = 1'b0, CTRL_WVALID = 1'b0, CTRL_ARVALID = 1'b0;
  logic        CTRL_BREADY = 1'b0, CTRL_RREADY = 1'b0;
  logic [10:0] CTRL_AWADDR = '0, CTRL_ARADDR = '0;
  logic [31:0] CTRL_WDATA = '0;
  logic [3:0]  CTRL_WSTRB = '0;
  logic        CTRL_AWREADY, CTRL_WREADY, CTRL_ARREADY, CTRL_BVALID, CTRL_RVALID;
  logic [1:0]  CTRL_BRESP, CTRL_RRESP;
  logic [31:0] CTRL_RDATA;
  logic        ctrlWrEn, ctrlRdEn, ctrlWrReady, ctrlRdValid;
  logic [10:0] ctrlAddr;
  logic [31:0] ctrlWrData, ctrlRdData;
  logic [3:0]  ctrlWrStrbs;

  int checkCount = 0;
  int passCount = 0;

  // Downstream responder configuration and state.
  int          wrWait = 0;
  int          rdMode = 0;
  int          rdDelay = 1;
  int          wrCnt = 0;
  int          rdCnt = 0;
  logic        rdPend = 1'b0;
  logic [8:0]  rdWord = '0;
  logic [31:0] memDn [512];
  logic [31:0] refMem [512];
  int          bCount = 0;
  int          rCount = 0;
  int          bothEn = 0;
  byte         orderLog [$];
  logic [89:0] outVec;

  always #5 clock = ~clock;

  axi4lite_ctrl_slave #(.RD_TIMEOUT(255)) dut (
    .CLOCK(clock), .RESETN(resetn),
    .CTRL_AWVALID(CTRL_AWVALID), .CTRL_AWREADY(CTRL_AWREADY), .CTRL_AWADDR(CTRL_AWADDR),
    .CTRL_WVALID(CTRL_WVALID), .CTRL_WREADY(CTRL_WREADY), .CTRL_WDATA(CTRL_WDATA), .CTRL_WSTRB(CTRL_WSTRB),
    .CTRL_BVALID(CTRL_BVALID), .CTRL_BREADY(CTRL_BREADY), .CTRL_BRESP(CTRL_BRESP),
    .CTRL_ARVALID(CTRL_ARVALID), .CTRL_ARREADY(CTRL_ARREADY), .CTRL_ARADDR(CTRL_ARADDR),
    .CTRL_RVALID(CTRL_RVALID), .CTRL_RREADY(CTRL_RREADY), .CTRL_RDATA(CTRL_RDATA), .CTRL_RRESP(CTRL_RRESP),
    .ctrlWrEn(ctrlWrEn), .ctrlRdEn(ctrlRdEn), .ctrlAddr(ctrlAddr), .ctrlWrData(ctrlWrData),
    .ctrlWrStrbs(ctrlWrStrbs), .ctrlWrReady(ctrlWrReady), .ctrlRdValid(ctrlRdValid), .ctrlRdData(ctrlRdData)
  );

  assign outVec = {CTRL_AWREADY, CTRL_WREADY, CTRL_ARREADY, CTRL_BVALID, CTRL_BRESP, CTRL_RVALID,
                   CTRL_RDATA, CTRL_RRESP, ctrlWrEn, ctrlRdEn, ctrlAddr, ctrlWrData, ctrlWrStrbs};

  // Byte-strobe merge: what a register sees after a strobed write.
  function automatic logic [31:0] mergeStrb(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

  // Downstream mux: write ready after wrWait cycles, read data same-cycle,
  // after rdDelay cycles, or never, depending on rdMode.
  assign ctrlWrReady = ctrlWrEn && (wrCnt >= wrWait);
  assign ctrlRdValid = (rdMode == 0) ? ctrlRdEn : ((rdMode == 1) && rdPend && (rdCnt >= rdDelay));
  assign ctrlRdData  = !ctrlRdValid ? 32'hDEAD_BEEF : ((rdMode == 0) ? memDn[ctrlAddr[10:2]] : memDn[rdWord]);

  // Responder state, downstream memory and event monitors.
  always @(posedge clock) begin
    if (!resetn) begin
      wrCnt  <= 0;
      rdPend <= 1'b0;
      rdCnt  <= 0;
    end else begin
      if (ctrlWrEn && !ctrlWrReady) wrCnt <= wrCnt + 1;
      else wrCnt <= 0;
      if (ctrlWrEn && ctrlWrReady) begin
        memDn[ctrlAddr[10:2]] <= mergeStrb(memDn[ctrlAddr[10:2]], ctrlWrData, ctrlWrStrbs);
        orderLog.push_back(8'h57);
      end
      if (ctrlRdEn) begin
        orderLog.push_back(8'h52);
        rdPend <= (rdMode == 1);
        rdCnt  <= 1;
        rdWord <= ctrlAddr[10:2];
      end else if (rdPend) begin
        if (ctrlRdValid) rdPend <= 1'b0;
        else rdCnt <= rdCnt + 1;
      end
    end
    if (ctrlWrEn && ctrlRdEn) bothEn <= bothEn + 1;
    if (CTRL_BVALID && CTRL_BREADY) bCount <= bCount + 1;
    if (CTRL_RVALID && CTRL_RREADY) rCount <= rCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic doReset();
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // Drive AW and W; W leads AW by wLead cycles. Returns one cycle after the last handshake.
  task automatic axiWrite(input logic [10:0] addr, input logic [31:0] data, input logic [3:0] strb, input int wLead);
    int  cyc;
    bit  awDone, wDone, awHs, wHs;
    cyc = 0; awDone = 0; wDone = 0;
    @(negedge clock);
    CTRL_AWADDR = addr; CTRL_WDATA = data; CTRL_WSTRB = strb;
    CTRL_WVALID = 1'b1;
    CTRL_AWVALID = (wLead == 0);
    while (!(awDone && wDone) && cyc < 100) begin
      awHs = CTRL_AWVALID && CTRL_AWREADY;
      wHs  = CTRL_WVALID && CTRL_WREADY;
      @(negedge clock);
      cyc++;
      if (awHs) begin CTRL_AWVALID = 1'b0; awDone = 1; end
      if (wHs) begin CTRL_WVALID = 1'b0; wDone = 1; end
      if (!awDone && cyc >= wLead) CTRL_AWVALID = 1'b1;
    end
    if (!(awDone && wDone)) checkOutput("write_handshake_timeout", 0, 1);
  endtask

  task automatic axiRead(input logic [10:0] addr);
    int cyc;
    bit hs;
    cyc = 0; hs = 0;
    @(negedge clock);
    CTRL_ARADDR = addr;
    CTRL_ARVALID = 1'b1;
    while (!hs && cyc < 100) begin
      hs = CTRL_ARREADY;
      @(negedge clock);
      cyc++;
    end
    CTRL_ARVALID = 1'b0;
    if (!hs) checkOutput("read_handshake_timeout", 0, 1);
  endtask

  task automatic collectB(input int readyDelay, input string tag);
    int guard = 0;
    while (!CTRL_BVALID && guard < 2000) begin @(negedge clock); guard++; end
    if (!CTRL_BVALID) checkOutput({tag, "_bvalid_timeout"}, 0, 1);
    else begin
      repeat (readyDelay) begin
        @(negedge clock);
        checkOutput({tag, "_bhold"}, CTRL_BVALID, 1);
      end
      checkOutput({tag, "_bresp"}, CTRL_BRESP, 2'b00);
      CTRL_BREADY = 1'b1;
      @(negedge clock);
      CTRL_BREADY = 1'b0;
      checkOutput({tag, "_bvalid_drop"}, CTRL_BVALID, 0);
    end
  endtask

  task automatic collectR(input int readyDelay, input logic [31:0] expData, input logic [1:0] expResp, input string tag);
    int          guard = 0;
    logic [33:0] first;
    while (!CTRL_RVALID && guard < 2000) begin @(negedge clock); guard++; end
    if (!CTRL_RVALID) checkOutput({tag, "_rvalid_timeout"}, 0, 1);
    else begin
      first = {CTRL_RRESP, CTRL_RDATA};
      repeat (readyDelay) begin
        @(negedge clock);
        checkOutput({tag, "_rhold"}, {CTRL_RVALID, CTRL_RRESP, CTRL_RDATA}, {1'b1, first});
      end
      checkOutput({tag, "_rdata"}, CTRL_RDATA, expData);
      checkOutput({tag, "_rresp"}, CTRL_RRESP, expResp);
      CTRL_RREADY = 1'b1;
      @(negedge clock);
      CTRL_RREADY = 1'b0;
      checkOutput({tag, "_rvalid_drop"}, CTRL_RVALID, 0);
    end
  endtask

  // Randomized single transactions against the word-level memory model.
  task automatic applyStimulus(input int iterations);
    logic [10:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expData;
    logic [1:0]  expResp;
    int          sel;
    int          timeoutsLeft = 2;
    for (int i = 0; i < iterations; i++) begin
      addr = 11'(($urandom_range(0, 15) * 4) + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        wrWait = $urandom_range(0, 3);
        axiWrite(addr, data, strb, $urandom_range(0, 2));
        checkOutput("rand_wr_bus", {ctrlWrEn, ctrlRdEn, ctrlAddr, ctrlWrData, ctrlWrStrbs},
                    {1'b1, 1'b0, addr & 11'h7FC, data, strb});
        collectB($urandom_range(0, 2), "rand_wr");
        refMem[addr / 4] = mergeStrb(refMem[addr / 4], data, strb);
      end else begin
        sel = $urandom_range(0, 9);
        if (sel == 0 && timeoutsLeft > 0) begin
          rdMode = 2;
          timeoutsLeft--;
        end else if (sel <= 4) begin
          rdMode = 1;
          rdDelay = $urandom_range(1, 4);
        end else begin
          rdMode = 0;
        end
        expData = (rdMode == 2) ? 32'h0 : refMem[addr / 4];
        expResp = (rdMode == 2) ? 2'b10 : 2'b00;
        axiRead(addr);
        checkOutput("rand_rd_bus", {ctrlRdEn, ctrlWrEn, ctrlAddr}, {1'b1, 1'b0, addr & 11'h7FC});
        collectR($urandom_range(0, 2), expData, expResp, "rand_rd");
      end
    end
    rdMode = 0;
    wrWait = 0;
  endtask

  // Main sequence: reset, directed scenarios, random phase, summary.
  initial begin
    int          cnt;
    int          bBefore;
    int          rBefore;
    logic [31:0] v;
    logic [31:0] d36;
    for (int i = 0; i < 512; i++) begin
      v = $urandom;
      memDn[i] = v;
      refMem[i] = v;
    end
    memDn[0] = 32'h1234_5678;
    refMem[0] = 32'h1234_5678;

    repeat (3) @(negedge clock);
    checkOutput("reset_outputs", outVec, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("release_readies", {CTRL_AWREADY, CTRL_WREADY, CTRL_ARREADY}, 3'b111);
    checkOutput("release_idle_bus", {ctrlWrEn, ctrlRdEn, CTRL_BVALID, CTRL_RVALID}, 0);

    $display("[TB] write with AW and W together");
    wrWait = 0;
    axiWrite(11'h064, 32'hA5A5_0001, 4'hF, 0);
    checkOutput("wr_min_bus", {ctrlWrEn, ctrlRdEn, ctrlAddr, ctrlWrData, ctrlWrStrbs},
                {1'b1, 1'b0, 11'h064, 32'hA5A5_0001, 4'hF});
    @(negedge clock);
    checkOutput("wr_min_bvalid", {CTRL_BVALID, CTRL_BRESP, ctrlWrEn}, {1'b1, 2'b00, 1'b0});
    collectB(0, "wr_min");
    refMem[11'h064 / 4] = mergeStrb(refMem[11'h064 / 4], 32'hA5A5_0001, 4'hF);

    $display("[TB] read with same-cycle data");
    rdMode = 0;
    axiRead(11'h000);
    checkOutput("rd_min_bus", {ctrlRdEn, ctrlWrEn, ctrlAddr}, {1'b1, 1'b0, 11'h000});
    @(negedge clock);
    checkOutput("rd_min_rvalid", {CTRL_RVALID, CTRL_RRESP, CTRL_RDATA}, {1'b1, 2'b00, 32'h1234_5678});
    collectR(1, 32'h1234_5678, 2'b00, "rd_min");

    $display("[TB] read timeout");
    rdMode = 2;
    axiRead(11'h460);
    checkOutput("rd_to_issue", {ctrlRdEn, ctrlAddr}, {1'b1, 11'h460});
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clock);
      if (CTRL_RVALID || ctrlRdEn) cnt++;
    end
    checkOutput("rd_to_early_activity", cnt, 0);
    @(negedge clock);
    checkOutput("rd_to_rvalid", {CTRL_RVALID, CTRL_RRESP, CTRL_RDATA}, {1'b1, 2'b10, 32'h0});
    collectR(0, 32'h0, 2'b10, "rd_to");
    rdMode = 0;

    $display("[TB] write with W leading and slow ready");
    wrWait = 4;
    d36 = $urandom;
    bBefore = bCount;
    axiWrite(11'h070, d36, 4'h5, 3);
    for (int i = 0; i < 5; i++) begin
      checkOutput("wr_slow_hold", {ctrlWrEn, ctrlAddr, ctrlWrData, ctrlWrStrbs, CTRL_BVALID},
                  {1'b1, 11'h070, d36, 4'h5, 1'b0});
      @(negedge clock);
    end
    checkOutput("wr_slow_done", {ctrlWrEn, CTRL_BVALID}, 2'b01);
    collectB(2, "wr_slow");
    repeat (3) @(negedge clock);
    checkOutput("wr_slow_one_b", bCount - bBefore, 1);
    refMem[11'h070 / 4] = mergeStrb(refMem[11'h070 / 4], d36, 4'h5);
    wrWait = 0;

    $display("[TB] arbitration between write and read");
    doReset();
    for (int round = 0; round < 2; round++) begin
      logic [31:0] wd;
      logic [31:0] rdExp;
      wd = $urandom;
      orderLog.delete();
      checkOutput("arb_readies", {CTRL_AWREADY, CTRL_WREADY, CTRL_ARREADY}, 3'b111);
      CTRL_AWADDR = 11'h100; CTRL_WDATA = wd; CTRL_WSTRB = 4'hF; CTRL_ARADDR = 11'h204;
      CTRL_AWVALID = 1'b1; CTRL_WVALID = 1'b1; CTRL_ARVALID = 1'b1;
      @(negedge clock);
      CTRL_AWVALID = 1'b0; CTRL_WVALID = 1'b0; CTRL_ARVALID = 1'b0;
      rdExp = refMem[11'h204 / 4];
      if (round == 0) begin
        checkOutput("arb1_first_write", {ctrlWrEn, ctrlRdEn}, 2'b10);
        collectB(0, "arb1");
        collectR(0, rdExp, 2'b00, "arb1");
      end else begin
        checkOutput("arb2_first_read", {ctrlWrEn, ctrlRdEn}, 2'b01);
        collectR(0, rdExp, 2'b00, "arb2");
        collectB(0, "arb2");
      end
      refMem[11'h100 / 4] = wd;
      checkOutput("arb_order_len", orderLog.size(), 2);
      if (orderLog.size() == 2)
        checkOutput("arb_order", {orderLog[0], orderLog[1]}, (round == 0) ? 16'h5752 : 16'h5257);
    end

    $display("[TB] reset during read wait");
    rdMode = 2;
    rBefore = rCount;
    axiRead(11'h0A8);
    repeat (10) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    checkOutput("midreset_outputs", outVec, 0);
    resetn = 1'b1;
    rdMode = 0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (CTRL_RVALID || CTRL_BVALID) cnt++;
      if (i == 2) checkOutput("midreset_readies", {CTRL_AWREADY, CTRL_WREADY, CTRL_ARREADY}, 3'b111);
    end
    checkOutput("midreset_no_resp", cnt, 0);
    checkOutput("midreset_r_count", rCount - rBefore, 0);

    $display("[TB] randomized phase");
    applyStimulus(40);
    checkOutput("never_both_enables", bothEn, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Guard against a hung simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
